// File: rtl/timer_ctrl.sv
// timer_ctrl: control and next-value stage for a two-mode (up / down) timer.
// It closes the loop around an external counter register: it reads the
// current count and produces the next count every clock, and it runs the
// idle/run/pause/done state machine, the tick prescaler and the
// start/clear button edge detection.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   mode       0 = count up to preset, 1 = count down from preset
//              (captured only when leaving IDLE)
//   start_btn  synchronised, debounced level; each rising edge toggles run/pause
//   clear_btn  synchronised, debounced level; each rising edge returns to IDLE
//   preset     countdown start value, or count-up limit (0 = free-running up)
//   count_q    current count from the counter register
//   count_d    next count to the counter register (combinational)
//   running    high in RUN
//   done       high in DONE
//   state      IDLE=00, RUN=01, PAUSE=10, DONE=11
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | count held at init value, waiting for a start edge
// RUN   | prescaler advancing, count steps once per TICK_DIV clocks
// PAUSE | count and prescaler frozen, start edge resumes
// DONE  | limit or zero reached, count held until a clear edge
module timer_ctrl #(
  parameter int BIT_SIZE = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                start_btn,
  input  logic                clear_btn,
  input  logic [BIT_SIZE-1:0] preset,
  input  logic [BIT_SIZE-1:0] count_q,
  output logic [BIT_SIZE-1:0] count_d,
  output logic                running,
  output logic                done,
  output logic [1:0]          state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_r_q, mode_r_d;
  logic          start_prev_q, clear_prev_q;

  logic                start_edge, clear_edge, tick;
  logic [BIT_SIZE-1:0] init_val, count_inc, count_dec;

  assign start_edge = start_btn & ~start_prev_q;
  assign clear_edge = clear_btn & ~clear_prev_q;
  assign tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign init_val   = mode ? preset : '0;
  assign count_inc  = count_q + 1'b1;
  // Down count saturates at zero instead of wrapping.
  assign count_dec  = (count_q == '0) ? '0 : count_q - 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      mode_r_q     <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mode_r_q     <= mode_r_d;
      start_prev_q <= start_btn;
      clear_prev_q <= clear_btn;
    end
  end

  // Next-state and prescaler
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    mode_r_d = mode_r_q;
    if (clear_edge) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            mode_r_d = mode;
            presc_d  = '0;
            state_d  = (mode && preset == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_d = '0;
            // A tick wins over a coincident start edge; the pause is dropped.
            if (!mode_r_q) begin
              if (preset != '0 && count_inc == preset) state_d = S_DONE;
            end else begin
              if (count_dec == '0) state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (start_edge) state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_edge) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    count_d = count_q;
    if (clear_edge || state_q == S_IDLE) begin
      count_d = init_val;
    end else if (tick) begin
      count_d = mode_r_q ? count_dec : count_inc;
    end
    running = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    state   = state_q;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  localparam int BS = 8;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          start_btn;
  logic          clear_btn;
  logic [BS-1:0] preset;
  logic [BS-1:0] count_q;
  logic [BS-1:0] count_d;
  logic          running;
  logic          done;
  logic [1:0]    state;

  logic          ld_en = 1'b0;
  logic [BS-1:0] ld_val = '0;

  int total = 0;
  int bad   = 0;

  // reference model: abstract state 0 idle, 1 run, 2 pause, 3 done
  int m_st, m_cnt, m_mode, m_runc, m_sp, m_cp;

  timer_ctrl #(.BIT_SIZE(BS), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start_btn(start_btn),
    .clear_btn(clear_btn), .preset(preset), .count_q(count_q),
    .count_d(count_d), .running(running), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // existing counter register, with a bench-only preload path
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count_q <= '0;
    else if (ld_en) count_q <= ld_val;
    else            count_q <= count_d;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_mode = 0; m_runc = 0; m_sp = 0; m_cp = 0;
  endtask

  // one clock edge of the timer, from the behavioural rules
  task automatic model_step();
    int se, ce, init, p;
    se = (start_btn && !m_sp) ? 1 : 0;
    ce = (clear_btn && !m_cp) ? 1 : 0;
    m_sp = int'(start_btn);
    m_cp = int'(clear_btn);
    p = int'(preset);
    init = mode ? p : 0;
    if (ce) begin
      m_cnt = init;
      m_st = 0;
    end else if (m_st == 0) begin
      m_cnt = init;
      if (se) begin
        m_mode = int'(mode);
        m_runc = 0;
        m_st = (mode && p == 0) ? 3 : 1;
      end
    end else if (m_st == 1) begin
      if (m_runc % TD == TD - 1) begin
        if (m_mode == 0) begin
          m_cnt = (m_cnt + 1) % 256;
          if (p != 0 && m_cnt == p) m_st = 3;
        end else begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_st = 3;
        end
      end else if (se) begin
        m_st = 2;
      end
      m_runc++;
    end else if (m_st == 2) begin
      if (se) m_st = 1;
    end
    if (ld_en) m_cnt = int'(ld_val);
  endtask

  // drive inputs, take one edge, compare against the model
  task automatic cyc(input logic s, input logic c, input logic m, input logic [BS-1:0] p);
    start_btn = s; clear_btn = c; mode = m; preset = p;
    @(posedge clk);
    model_step();
    #1;
    ld_en = 1'b0;
    chk("state", int'(state), m_st);
    chk("count", int'(count_q), m_cnt);
    chk("running", int'(running), (m_st == 1) ? 1 : 0);
    chk("done", int'(done), (m_st == 3) ? 1 : 0);
  endtask

  initial begin
    logic s, c, m;
    logic [BS-1:0] p;

    // reset state, combinational init value
    rst = 1'b1; mode = 1'b1; preset = 8'd5; start_btn = 1'b0; clear_btn = 1'b0;
    model_reset();
    #1;
    chk("rst_count_d_down", int'(count_d), 5);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_state", int'(state), 0);
    mode = 1'b0;
    #1;
    chk("rst_count_d_up", int'(count_d), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // countdown from 3
    cyc(0, 0, 1, 8'd3);
    cyc(1, 0, 1, 8'd3);
    chk("cd_running", int'(running), 1);
    chk("cd_start_count", int'(count_q), 3);
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 1, 8'd3);
      if (i == 4)  chk("cd_k4", int'(count_q), 2);
      if (i == 8)  chk("cd_k8", int'(count_q), 1);
      if (i == 11) chk("cd_not_done_yet", int'(done), 0);
      if (i == 12) begin
        chk("cd_k12", int'(count_q), 0);
        chk("cd_done", int'(done), 1);
      end
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'd3);
    chk("cd_hold", int'(count_q), 0);
    cyc(1, 0, 1, 8'd3);
    chk("cd_start_ignored", int'(state), 3);
    cyc(0, 1, 0, 8'd10);
    chk("cd_clear_idle", int'(state), 0);

    // count up with pause, limit 10
    cyc(0, 0, 0, 8'd10);
    cyc(1, 0, 0, 8'd10);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'd10);
    chk("up_two", int'(count_q), 2);
    cyc(1, 0, 0, 8'd10);
    chk("up_paused", int'(state), 2);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 8'd10);
    chk("up_pause_hold", int'(count_q), 2);
    cyc(1, 0, 0, 8'd10);
    cyc(0, 0, 0, 8'd10);
    cyc(0, 0, 0, 8'd10);
    chk("up_resume_r2", int'(count_q), 2);
    cyc(0, 0, 0, 8'd10);
    chk("up_resume_r3", int'(count_q), 3);
    for (int i = 0; i < 40 && !done; i++) cyc(0, 0, 0, 8'd10);
    chk("up_done", int'(done), 1);
    chk("up_final", int'(count_q), 10);
    cyc(0, 1, 0, 8'd10);

    // down with preset 0: straight to DONE
    cyc(0, 0, 1, 8'd0);
    cyc(1, 0, 1, 8'd0);
    chk("d0_state", int'(state), 3);
    chk("d0_count", int'(count_q), 0);
    cyc(0, 1, 0, 8'd0);

    // free-running up from 254
    cyc(0, 0, 0, 8'd0);
    ld_en = 1'b1; ld_val = 8'd254;
    cyc(1, 0, 0, 8'd0);
    chk("fr_preload", int'(count_q), 254);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, 8'd0);
      if (i == 4)  chk("fr_255", int'(count_q), 255);
      if (i == 8)  chk("fr_wrap", int'(count_q), 0);
      if (i == 12) chk("fr_one", int'(count_q), 1);
    end
    chk("fr_no_done", int'(done), 0);

    // clear and start in the same cycle during RUN
    cyc(1, 1, 0, 8'd10);
    chk("prio_idle", int'(state), 0);
    chk("prio_count", int'(count_q), 0);

    // start edge coinciding with a tick
    cyc(0, 0, 0, 8'd10);
    cyc(1, 0, 0, 8'd10);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'd10);
    cyc(1, 0, 0, 8'd10);
    chk("tick_start_count", int'(count_q), 1);
    chk("tick_start_run", int'(state), 1);

    // reset in the middle of RUN
    for (int i = 0; i < 40 && count_q != 8'd5; i++) cyc(0, 0, 0, 8'd10);
    chk("mid_reached5", int'(count_q), 5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_running", int'(running), 0);
    chk("mid_state", int'(state), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'd10);
    chk("mid_stays_idle", int'(state), 0);

    // randomized run against the model
    s = 1'b0; c = 1'b0; m = 1'b0; p = 8'd6;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0)  s = ~s;
      if ($urandom_range(39) == 0) c = ~c;
      if ($urandom_range(15) == 0) m = ~m;
      if ($urandom_range(60) == 0) p = 8'($urandom_range(12));
      cyc(s, c, m, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control and next-value stage for the two-mode timer. Sits directly upstream of the existing counter register, closing the loop: reads the current count (`count_q`), decides the next count (`count_d`) on every clock, and runs the run/pause/done state machine, prescaler and button edge detection. Mode 0 is count-up (stopwatch up to a limit); mode 1 is count-down (from a preset to zero).

## Interface
- `BIT_SIZE`, 8: width of the count, preset and count path.
- `TICK_DIV`, 4: clock cycles per count step; synthesis overrides this for a 1 Hz tick. Must be ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mode`  in  1  0 = count up, 1 = count down; sampled only on leaving IDLE.
- `start_btn`  in  1  level, already synchronised and debounced; each rising edge toggles run/pause.
- `clear_btn`  in  1  level, already synchronised and debounced; each rising edge returns to IDLE.
- `preset`  in  BIT_SIZE  countdown start value, or count-up limit.
- `count_q`  in  BIT_SIZE  current count from the counter register.
- `count_d`  out  BIT_SIZE  next count to the counter register; combinational.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `state`  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Edge detect: registered `start_prev`/`clear_prev`. `start_edge = start_btn & ~start_prev`; `clear_edge` is formed the same way. Both `*_prev` registers reset to 0.
- Init value: `mode ? preset : 0`, using the live `mode` input.
- IDLE:
  - `count_d` = init value.
  - `start_edge` latches `mode` into `mode_r` and clears the prescaler.
  - Next state: DONE if `mode=1` and `preset=0`; otherwise RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. `tick` = (prescaler = TICK_DIV-1); the prescaler wraps to 0 on tick.
  - No tick: `count_d = count_q`.
  - Tick, up mode: `count_d = count_q+1`, mod 2^BIT_SIZE. Go to DONE if `count_q+1 == preset` and `preset ≠ 0`. `preset = 0` means free-running: 2^BIT_SIZE−1 wraps to 0, never DONE.
  - Tick, down mode: if `count_q > 0`, `count_d = count_q−1` and go to DONE when the result is 0. If `count_q = 0`, hold at 0 and go to DONE. Never wraps.
  - `start_edge` without tick → PAUSE.
- PAUSE:
  - `count_d = count_q`; prescaler frozen, not cleared.
  - `start_edge` → RUN, prescaler resumes from its held value.
- DONE: `count_d = count_q`, `start_edge` ignored.
- `clear_edge`, in any state → IDLE. It has priority over `start_edge` and over tick in the same cycle, and `count_d` takes the init value that cycle.
- `start_edge` coinciding with tick in RUN: the tick's count step and any DONE transition apply; the pause request is dropped.
- `mode` changes outside IDLE are ignored; `mode_r` is used.

## Timing
- Reset (async, immediate, no clock needed):
  - state IDLE, prescaler 0, `mode_r` 0, `*_prev` 0.
  - `running` 0, `done` 0, `state` 00.
  - `count_d` = init value (combinational).
- Latencies:
  - `start_btn` high before clock edge k (previous sample low) → `running` = 1 after edge k.
  - First tick asserts in the cycle where the prescaler reaches TICK_DIV-1, so the count register updates at edge k+TICK_DIV. Subsequent steps follow every TICK_DIV edges.
  - `done` rises after the same edge at which the final count value is captured.
  - `clear_edge` → IDLE after 1 edge. The counter register holds the init value after that edge.
- `running` and `done` are decoded from registered state and are glitch-free.
- Reset asserted mid-RUN: outputs change asynchronously. After reset releases, the block waits in IDLE for a new `start_edge`.

## Test plan
Bench closes the loop through the existing counter register. Parameters: BIT_SIZE=8, TICK_DIV=4.
- Reset: `rst`=1, `mode`=1, `preset`=5 → `count_d`=5, `running`=0, `done`=0, `state`=00. Switch `mode` to 0 → `count_d`=0.
- Countdown: `preset`=3, `mode`=1, start edge at edge k → count 2 at k+4, 1 at k+8, 0 at k+12. `done`=1 after k+12; count holds 0 for 20 further cycles; another start edge is ignored.
- Up with pause: `preset`=10, `mode`=0, start edge; pause after count 2 with prescaler at 1 → count holds 2 for 20 cycles. Resume → count 3 exactly 3 edges later; `done` rises when count reaches 10.
- Edge cases:
  - Down, `preset`=0: start edge → DONE after one edge, count 0.
  - Up, `preset`=0, register preloaded to 254: counts 255, 0, 1; `done` stays 0.
- Priority: clear and start edges in the same cycle during RUN → IDLE, count 0 (up mode).
  - Separately, a start edge on a tick cycle → count still steps, state stays RUN.
- Reset mid-RUN: assert `rst` between clock edges at count 5 → `running`=0 immediately, `state`=00. After release, the block stays IDLE until a start edge.
